// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered hex driver for a multi-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     dp_in_i,
   input  logic                  load_i,
   output logic [6:0]            segments_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     digit_en_o,
   output logic                  frame_tick_o
);

   localparam int   CNT_W = $clog2(SCAN_DIV);
   localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic INV   = (ACTIVE_LOW != 0);

   typedef enum logic {ST_BLANK, ST_SHOW} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d, active_val_q, active_val_d;
   logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
   logic                  pending_q, pending_d;
   logic                  tick_q, tick_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     en_q, en_d;
   logic                  slot_end, frame_end, lz_blank;
   logic [3:0]            nib;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
      endcase
   endfunction

`ifdef SEG7_LZB_EN
   // Digit idx is a leading zero when it and every higher nibble are zero; digit 0 always shows.
   always_comb begin
      lz_blank = (idx_q != '0);
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(idx_q) && active_val_q[4*j +: 4] != 4'h0) lz_blank = 1'b0;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
   assign nib       = active_val_q[4*idx_q +: 4];

   always_comb begin
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      active_val_d = active_val_q;
      active_dp_d  = active_dp_q;
      pending_d    = pending_q;
      tick_d       = frame_end;
      seg_d        = 7'h00;
      dp_d         = 1'b0;
      en_d         = '0;

      if (slot_end) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      state_d = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;

      // The boundary transfer sees the pre-edge shadow; a coincident load re-arms pending.
      if (frame_end && pending_q) begin
         active_val_d = shadow_val_q;
         active_dp_d  = shadow_dp_q;
         pending_d    = 1'b0;
      end
      if (load_i) begin
         shadow_val_d = value_i;
         shadow_dp_d  = dp_in_i;
         pending_d    = 1'b1;
      end

      if (state_q == ST_SHOW) begin
         if (lz_blank) begin
            if (active_dp_q[idx_q]) begin
               en_d[idx_q] = 1'b1;
               dp_d        = 1'b1;
            end
         end else begin
            en_d[idx_q] = 1'b1;
            seg_d       = glyph(nib);
            dp_d        = active_dp_q[idx_q];
         end
      end

      seg_d = seg_d ^ {7{INV}};
      dp_d  = dp_d ^ INV;
      en_d  = en_d ^ {DIGITS{INV}};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         active_val_q <= '0;
         active_dp_q  <= '0;
         pending_q    <= 1'b0;
         tick_q       <= 1'b0;
         seg_q        <= {7{INV}};
         dp_q         <= INV;
         en_q         <= {DIGITS{INV}};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         active_val_q <= active_val_d;
         active_dp_q  <= active_dp_d;
         pending_q    <= pending_d;
         tick_q       <= tick_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         en_q         <= en_d;
      end
   end

   assign segments_o   = seg_q;
   assign dp_o         = dp_q;
   assign digit_en_o   = en_q;
   assign frame_tick_o = tick_q;

endmodule
